// File: rtl/wb_dbg_pkg.sv
// Shared types and constants for the UART debug bus response path.
// Used by wb_rsp_encoder and wb_rsp_fifo (the FIFO is built only with WB_RSP_FIFO_EN).
package wb_dbg_pkg;

  localparam logic [1:0] RSP_ACK  = 2'b00;
  localparam logic [1:0] RSP_DATA = 2'b01;
  localparam logic [1:0] RSP_ERR  = 2'b10;
  localparam logic [1:0] RSP_RST  = 2'b11;

  localparam logic [7:0] ASCII_K = 8'h4B;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HEX,
    EOL,
    GAP
  } rsp_state_e;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] data;
  } rsp_word_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    // 'A' - 10 = 8'h37, so both ranges are a single add
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] hdr_ascii(input logic [1:0] code);
    case (code)
      RSP_ACK:  return ASCII_K;
      RSP_DATA: return ASCII_R;
      RSP_ERR:  return ASCII_E;
      default:  return ASCII_Z;
    endcase
  endfunction

endpackage

// File: rtl/wb_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO for response words.
// Instantiated by wb_rsp_encoder only when WB_RSP_FIFO_EN is defined.
module wb_rsp_fifo
  import wb_dbg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_push,
  input  rsp_word_t i_data,
  input  logic      i_pop,
  output rsp_word_t o_data,
  output logic      o_empty,
  output logic      o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  rsp_word_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, empty_q;
  logic            push_ok, pop_ok;

  assign pop_ok  = i_pop && !empty_q;
  // A pop frees the slot at the same edge, so a push into a full FIFO is legal then
  assign push_ok = i_push && (!full_q || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_q];
  assign o_empty = empty_q;
  assign o_full  = full_q;

endmodule

// File: rtl/wb_rsp_encoder.sv
// Serialises 34-bit Wishbone response words into ASCII bytes for the UART TX.
// Define WB_RSP_FIFO_EN to buffer accepted words in a FIFO_DEPTH-entry FIFO.
module wb_rsp_encoder
  import wb_dbg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  EOL_CHAR   = 8'h0A
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rsp_stb,
  input  logic [33:0] i_rsp_word,
  output logic        o_rsp_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_stb,
  input  logic        i_tx_busy
);

  rsp_state_e  state_q, state_d;
  rsp_word_t   word_q, word_d;
  logic [3:0]  nib_q, nib_d;
  logic        eol_q, eol_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_stb_q, tx_stb_d;
  logic        start;
  rsp_word_t   start_word;
  logic [31:0] hex_shift;

`ifdef WB_RSP_FIFO_EN
  logic      fifo_push, fifo_pop, fifo_empty, fifo_full;
  rsp_word_t fifo_data;

  assign fifo_push  = i_rsp_stb && !fifo_full;
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign start      = !fifo_empty;
  assign start_word = fifo_data;
  assign o_rsp_busy = fifo_full;

  wb_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (fifo_push),
    .i_data    (rsp_word_t'(i_rsp_word)),
    .i_pop     (fifo_pop),
    .o_data    (fifo_data),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full)
  );
`else
  logic busy_q, busy_d;
  logic unused_depth;

  assign unused_depth = ^FIFO_DEPTH;
  assign start        = i_rsp_stb && !busy_q;
  assign start_word   = rsp_word_t'(i_rsp_word);
  assign busy_d       = (state_d != IDLE);
  assign o_rsp_busy   = busy_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) busy_q <= 1'b0;
    else            busy_q <= busy_d;
  end
`endif

  // Current nibble, MSB first, selected by shifting rather than a variable part-select
  assign hex_shift = word_q.data << {nib_q[2:0], 2'b00};

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    nib_d     = nib_q;
    eol_d     = eol_q;
    tx_data_d = tx_data_q;
    tx_stb_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = start_word;
          nib_d   = '0;
          eol_d   = 1'b0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (!i_tx_busy) begin
          tx_data_d = hdr_ascii(word_q.code);
          tx_stb_d  = 1'b1;
          state_d   = GAP;
        end
      end
      HEX: begin
        if (!i_tx_busy) begin
          tx_data_d = hex_ascii(hex_shift[31:28]);
          tx_stb_d  = 1'b1;
          nib_d     = nib_q + 4'd1;
          state_d   = GAP;
        end
      end
      EOL: begin
        if (!i_tx_busy) begin
          tx_data_d = EOL_CHAR;
          tx_stb_d  = 1'b1;
          eol_d     = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        if ((word_q.code == RSP_DATA) && (nib_q < 4'd8)) state_d = HEX;
        else if (!eol_q)                                 state_d = EOL;
        else                                             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      nib_q     <= '0;
      eol_q     <= 1'b0;
      tx_data_q <= '0;
      tx_stb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      nib_q     <= nib_d;
      eol_q     <= eol_d;
      tx_data_q <= tx_data_d;
      tx_stb_q  <= tx_stb_d;
    end
  end

  assign o_tx_data = tx_data_q;
  assign o_tx_stb  = tx_stb_q;

endmodule
